// File: rtl/dcache_pkg.sv
// Shared types and constants for the data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        FILL,
        WRITE_WAIT
    } dcache_state_t;

    // Low address bits that select a byte within a word.
    localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

    localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/data_cache_controller.sv
// Load/store sequencer between the CPU, a two-way data cache and main memory.
// Define DCACHE_CTRL_STATS_EN to add saturating read hit/miss counters.
module data_cache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    output logic                  cache_fill_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
`ifdef DCACHE_CTRL_STATS_EN
    output logic [STAT_W-1:0]     stat_hits_o,
    output logic [STAT_W-1:0]     stat_misses_o,
`endif
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_OFFSET_MASK);

    dcache_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] fill_q,  fill_d;
    logic                  hit_q,   hit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            hit_q   <= hit_d;
        end
    end

    // Memory-side address and store data always come from the request latches.
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        fill_d        = fill_q;
        hit_d         = hit_q;
        rdata_o       = '0;
        stall_o       = 1'b0;
        cache_addr_o  = addr_q;
        cache_fill_o  = 1'b0;
        cache_wdata_o = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;

        case (state_q)
            IDLE: begin
                cache_addr_o = addr_i;
                if (req_i) begin
                    if (we_i) begin
                        stall_o = 1'b1;
                        addr_d  = addr_i & ALIGN_MASK;
                        wdata_d = wdata_i;
                        hit_d   = cache_hit_i;
                        state_d = WRITE_WAIT;
                    end else if (cache_hit_i) begin
                        rdata_o = cache_rdata_i;
                    end else begin
                        stall_o = 1'b1;
                        addr_d  = addr_i & ALIGN_MASK;
                        state_d = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                if (mem_ready_i) begin
                    fill_d  = mem_rdata_i;
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_fill_o  = 1'b1;
                cache_wdata_o = fill_q;
                rdata_o       = fill_q;
                state_d       = IDLE;
            end
            WRITE_WAIT: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                stall_o   = ~mem_ready_i;
                // Write-update only when the line was present at acceptance.
                if (mem_ready_i) begin
                    cache_fill_o  = hit_q;
                    cache_wdata_o = hit_q ? wdata_q : '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [STAT_W-1:0] hits_q,   hits_d;
    logic [STAT_W-1:0] misses_q, misses_d;
    logic              rd_req_c;

    assign rd_req_c = (state_q == IDLE) && req_i && !we_i;

    // Saturating counters of accepted read hits and misses.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (rd_req_c) begin
            if (cache_hit_i) begin
                if (hits_q != '1) hits_d = hits_q + STAT_W'(1);
            end else if (misses_q != '1) begin
                misses_d = misses_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`endif

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Sequencing controller between the CPU load/store stage and the two-way set-associative data cache plus main data memory. It accepts one word request at a time, serves read hits from the cache with no stall, and handles read misses by fetching from memory and filling the cache. Stores are write-through with write-update on hit and no write-allocate. The CPU pipeline is held via `stall_o` while any multi-cycle operation is in flight.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_i` input, 1 bit: CPU memory request valid.
- `we_i` input, 1 bit: 1 = store, 0 = load.
- `addr_i` input, ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `wdata_i` input, DATA_WIDTH: store data.
- `rdata_o` output, DATA_WIDTH: load data.
- `stall_o` output, 1 bit: CPU must hold its request and inputs.
- `cache_addr_o` output, ADDR_WIDTH: lookup/fill address to the cache.
- `cache_hit_i` input, 1 bit: combinational hit from the cache.
- `cache_rdata_i` input, DATA_WIDTH: hit data from the cache.
- `cache_fill_o` output, 1 bit: one-cycle write strobe into the cache.
- `cache_wdata_o` output, DATA_WIDTH: fill/update data.
- `mem_req_o` output, 1 bit: memory request.
- `mem_we_o` output, 1 bit: memory write.
- `mem_addr_o` output, ADDR_WIDTH: word-aligned address (bits [1:0] = 0).
- `mem_wdata_o` output, DATA_WIDTH: memory write data.
- `mem_ready_i` input, 1 bit: memory completes the current request this cycle.
- `mem_rdata_i` input, DATA_WIDTH: read data, valid when `mem_ready_i` = 1.

## Operation
States: IDLE, READ_WAIT, FILL, WRITE_WAIT.
- **IDLE**
  - `cache_addr_o` = `addr_i`.
  - Read with `req_i`=1, `we_i`=0, `cache_hit_i`=1: `rdata_o` = `cache_rdata_i`, `stall_o`=0, stay in IDLE.
  - Read with `req_i`=1, `we_i`=0, `cache_hit_i`=0: `stall_o`=1 combinationally; latch the word-aligned address; go to READ_WAIT.
  - Write with `req_i`=1, `we_i`=1: `stall_o`=1; latch address, data and the hit flag; go to WRITE_WAIT.
- **READ_WAIT**
  - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = latched address, `stall_o`=1.
  - On `mem_ready_i`=1: capture `mem_rdata_i` into the fill buffer; go to FILL.
- **FILL**
  - `cache_fill_o`=1, `cache_addr_o` = latched address, `cache_wdata_o` = fill buffer.
  - `rdata_o` = fill buffer, `stall_o`=0; go to IDLE.
  - The cache chooses the replacement way; the controller does not select a way.
- **WRITE_WAIT**
  - `mem_req_o`=1, `mem_we_o`=1; `mem_wdata_o` and `mem_addr_o` come from the latches.
  - On `mem_ready_i`=1: `stall_o`=0; if the latched hit flag is set, `cache_fill_o`=1 with `cache_wdata_o` = latched data; go to IDLE.
- **Inputs while busy:** CPU inputs are ignored outside IDLE. All outputs use latched values.
- **mem_ready_i in IDLE/FILL:** ignored.
- **Reset mid-operation:** return to IDLE the next edge. `mem_req_o` drops, no fill is issued, and the in-flight request is discarded.

## Timing
- **Reset values:** state IDLE; `stall_o`, `mem_req_o`, `mem_we_o`, `cache_fill_o` = 0; `rdata_o`, `mem_addr_o`, `mem_wdata_o`, `cache_wdata_o` = 0.
- **Read hit:** 0 stall cycles.
- **Read miss:** stall cycles = 2 + W, where W is the number of cycles `mem_ready_i` stays low after `mem_req_o` rises.
- **Write:** stall cycles = 1 + W.
- **mem_req_o** is held constant until the cycle `mem_ready_i`=1 inclusive. It must be low the cycle after completion.
- **Back-to-back requests:** a new request is accepted in the first IDLE cycle after completion.

## Configuration
- **`DCACHE_CTRL_STATS_EN` defined:**
  - Adds 32-bit outputs `stat_hits_o` and `stat_misses_o`.
  - `stat_hits_o` counts accepted read hits; `stat_misses_o` counts read misses (one per IDLE->READ_WAIT).
  - Both counters clear on `rst` and saturate at all-ones.
- **Not defined:** the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- **Package `dcache_pkg`:**
  - `dcache_state_t` enum (IDLE, READ_WAIT, FILL, WRITE_WAIT).
  - Word-alignment mask constant.
  - Stats counter width constant (32).
- **Module layout:** single module with no sub-module. The FSM, latches and optional counters fit in one file.

## Test plan
- **Read hit:** read `addr_i`=0x0000_0010 with `cache_hit_i`=1 and `cache_rdata_i`=0xDEAD_BEEF -> `rdata_o`=0xDEAD_BEEF, `stall_o`=0, `mem_req_o`=0.
- **Read miss:** read 0x0000_0024 miss, memory ready after W=3 with 0x1234_5678 -> `stall_o` high for 5 cycles; `mem_addr_o`=0x0000_0024; FILL cycle has `cache_fill_o`=1 and `rdata_o`=0x1234_5678.
- **Store hit:** store 0x0000_0008, data 0xA5A5_A5A5, `cache_hit_i`=1, W=0 -> `mem_we_o`=1 for 1 cycle; `cache_fill_o`=1 with 0xA5A5_A5A5 in the ready cycle; 1 stall cycle.
- **Store miss:** store miss to 0x0000_0103 -> `mem_addr_o`=0x0000_0100; `cache_fill_o` never asserted.
- **Reset during read miss:** assert `rst` in READ_WAIT -> next cycle `mem_req_o`=0 and `stall_o`=0; a later `mem_ready_i` pulse causes no fill.
- **Stats (`DCACHE_CTRL_STATS_EN`):** 3 hits then 2 misses -> `stat_hits_o`=3, `stat_misses_o`=2; both read 0 after `rst`.
